countdown_timer_ctrl: RTL and testbench

Sequencing controller for a reloadable tick down-counter used by game logic, e.g. power-up durations and enemy spawn intervals driven by the per-frame strobe. It accepts a period and mode through a valid/ready configuration port, arms and runs the counter on command, and supports pause/resume and stop. It emits a single-cycle expire pulse, either once (one-shot) or every period (periodic). It sits between the game FSM and the frame/tick strobe source.

---
 rtl/timer_pkg.sv | 24 ++
 rtl/countdown_timer_ctrl_down_cnt.sv | 41 ++++
 rtl/countdown_timer_ctrl.sv | 136 +++++++++++++
 tb/tb_countdown_timer_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the countdown timer controller: state encoding,
// default counter width and small state-decode helpers.
package timer_pkg;

  localparam int unsigned TIMER_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

  // Counter owns the period while running or paused.
  function automatic logic state_is_busy(input timer_state_e s);
    return (s == ST_RUN) || (s == ST_PAUSE);
  endfunction

  // Configuration may only change while the counter is parked.
  function automatic logic state_accepts_cfg(input timer_state_e s);
    return (s == ST_IDLE) || (s == ST_DONE);
  endfunction

endpackage

// File: rtl/countdown_timer_ctrl_down_cnt.sv
// WIDTH-bit loadable down-counter with a flag marking the last tick of a period.
module down_cnt #(
  parameter int unsigned WIDTH = timer_pkg::TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             ce,
  output logic [WIDTH-1:0] count,
  output logic             is_one
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (ce) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments only; the reset is
  // synchronous and active-low, matching the rest of this codebase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign is_one = (count_q == WIDTH'(1));

endmodule

// File: rtl/countdown_timer_ctrl.sv
// Reloadable tick down-counter sequencer: config port, start/stop/pause
// control with stop > start > pause > tick priority, one-cycle expire pulse.
module countdown_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             tick,
  output logic             expire,
  output logic [WIDTH-1:0] remaining,
  output logic             busy,
  output logic [1:0]       state
);

  timer_state_e     state_d, state_q;
  logic [WIDTH-1:0] period_d, period_q;
  logic             periodic_d, periodic_q;
  logic             expire_d, expire_q;
  logic             busy_d, busy_q;

  logic             cfg_fire;
  logic [WIDTH-1:0] cfg_period_norm;
  logic [WIDTH-1:0] start_period;

  logic             cnt_load;
  logic [WIDTH-1:0] cnt_load_val;
  logic             cnt_ce;
  logic [WIDTH-1:0] cnt_value;
  logic             cnt_is_one;

  assign cfg_ready       = state_accepts_cfg(state_q);
  assign cfg_fire        = cfg_valid && cfg_ready;
  assign cfg_period_norm = (cfg_period == '0) ? WIDTH'(1) : cfg_period;
  // A handshake in the same cycle as start supplies the period directly.
  assign start_period    = cfg_fire ? cfg_period_norm : period_q;

  always_comb begin
    period_d   = period_q;
    periodic_d = periodic_q;
    if (cfg_fire) begin
      period_d   = cfg_period_norm;
      periodic_d = cfg_periodic;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_ce       = 1'b0;
    expire_d     = 1'b0;

    if (stop) begin
      state_d  = ST_IDLE;
      cnt_load = 1'b1;
    end else if (start) begin
      cnt_load     = 1'b1;
      cnt_load_val = start_period;
      // A restart while the pause level is still held keeps the count frozen.
      state_d      = (state_q == ST_PAUSE && pause) ? ST_PAUSE : ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick) begin
            if (cnt_is_one) begin
              expire_d = 1'b1;
              cnt_load = 1'b1;
              if (periodic_q) begin
                cnt_load_val = period_q;
              end else begin
                state_d = ST_DONE;
              end
            end else begin
              cnt_ce = 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign busy_d = state_is_busy(state_d);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      period_q   <= WIDTH'(1);
      periodic_q <= 1'b0;
      expire_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      expire_q   <= expire_d;
      busy_q     <= busy_d;
    end
  end

  down_cnt #(
    .WIDTH (WIDTH)
  ) u_down_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .ce       (cnt_ce),
    .count    (cnt_value),
    .is_one   (cnt_is_one)
  );

  assign expire    = expire_q;
  assign remaining = cnt_value;
  assign busy      = busy_q;
  assign state     = state_q;

endmodule

// File: tb/tb_countdown_timer_ctrl.sv
// Directed bench for countdown_timer_ctrl with hand-computed expectations.
module tb_countdown_timer_ctrl;

  localparam int unsigned W = 16;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_period;
  logic         cfg_periodic;
  logic         start;
  logic         stop;
  logic         pause;
  logic         tick;
  logic         expire;
  logic [W-1:0] remaining;
  logic         busy;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  countdown_timer_ctrl #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_periodic (cfg_periodic),
    .start        (start),
    .stop         (stop),
    .pause        (pause),
    .tick         (tick),
    .expire       (expire),
    .remaining    (remaining),
    .busy         (busy),
    .state        (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input logic [W-1:0] p, input logic per);
    cfg_valid = 1'b1; cfg_period = p; cfg_periodic = per;
    cyc();
    cfg_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [1:0] st, input logic [W-1:0] rem,
                           input logic exp_e, input logic exp_b);
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".remaining"}, 32'(remaining), 32'(rem));
    check({tag, ".expire"}, 32'(expire), 32'(exp_e));
    check({tag, ".busy"}, 32'(busy), 32'(exp_b));
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_period = '0; cfg_periodic = 1'b0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; tick = 1'b0;
    cyc(); cyc();
    rst_n = 1'b1;
    check_out("reset", S_IDLE, 16'd0, 1'b0, 1'b0);
    check("reset.cfg_ready", 32'(cfg_ready), 32'd1);

    // One-shot, period 3.
    configure(16'd3, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    check_out("os.start", S_RUN, 16'd3, 1'b0, 1'b1);
    tick = 1'b1;
    cyc(); check_out("os.t1", S_RUN, 16'd2, 1'b0, 1'b1);
    cyc(); check_out("os.t2", S_RUN, 16'd1, 1'b0, 1'b1);
    cyc(); check_out("os.t3", S_DONE, 16'd0, 1'b1, 1'b0);
    tick = 1'b0;
    cyc(); check_out("os.after", S_DONE, 16'd0, 1'b0, 1'b0);
    check("os.cfg_ready", 32'(cfg_ready), 32'd1);

    // Periodic, period 2, six ticks.
    configure(16'd2, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    check_out("per.start", S_RUN, 16'd2, 1'b0, 1'b1);
    tick = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      cyc();
      check_out($sformatf("per.t%0d", i), S_RUN, (i % 2 == 0) ? 16'd2 : 16'd1,
                (i % 2 == 0), 1'b1);
    end
    tick = 1'b0;
    cyc(); check_out("per.quiet", S_RUN, 16'd2, 1'b0, 1'b1);
    check("per.cfg_ready_busy", 32'(cfg_ready), 32'd0);
    stop = 1'b1; cyc(); stop = 1'b0;
    check_out("per.stop", S_IDLE, 16'd0, 1'b0, 1'b0);

    // Pause, period 5: 2 ticks, 4 paused cycles with ticks, resume, 3 ticks.
    configure(16'd5, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    tick = 1'b1;
    cyc(); cyc();
    check_out("pz.pre", S_RUN, 16'd3, 1'b0, 1'b1);
    pause = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_out($sformatf("pz.hold%0d", i), S_PAUSE, 16'd3, 1'b0, 1'b1);
    end
    pause = 1'b0; tick = 1'b0;
    cyc(); check_out("pz.resume", S_RUN, 16'd3, 1'b0, 1'b1);
    tick = 1'b1;
    cyc(); check_out("pz.t3", S_RUN, 16'd2, 1'b0, 1'b1);
    cyc(); check_out("pz.t4", S_RUN, 16'd1, 1'b0, 1'b1);
    cyc(); check_out("pz.t5", S_DONE, 16'd0, 1'b1, 1'b0);
    tick = 1'b0;

    // stop+start+tick in RUN, then start+tick from IDLE.
    configure(16'd4, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    check_out("pri.run", S_RUN, 16'd3, 1'b0, 1'b1);
    stop = 1'b1; start = 1'b1; tick = 1'b1;
    cyc(); stop = 1'b0;
    check_out("pri.stop", S_IDLE, 16'd0, 1'b0, 1'b0);
    cyc(); start = 1'b0; tick = 1'b0;
    check_out("pri.start_tick", S_RUN, 16'd4, 1'b0, 1'b1);

    // Config offered while RUN is ignored; period stays 4.
    check("cfg.ready_run", 32'(cfg_ready), 32'd0);
    configure(16'd0, 1'b1);
    check_out("cfg.ignored", S_RUN, 16'd4, 1'b0, 1'b1);
    tick = 1'b1;
    cyc(); cyc(); cyc();
    check_out("cfg.t3", S_RUN, 16'd1, 1'b0, 1'b1);
    cyc(); check_out("cfg.t4", S_DONE, 16'd0, 1'b1, 1'b0);
    tick = 1'b0;
    // Period 0 after DONE is accepted and stored as 1.
    configure(16'd0, 1'b0);
    start = 1'b1; tick = 1'b1;
    cyc(); start = 1'b0;
    check_out("p0.start", S_RUN, 16'd1, 1'b0, 1'b1);
    cyc(); tick = 1'b0;
    check_out("p0.expire", S_DONE, 16'd0, 1'b1, 1'b0);

    // Reset mid-RUN at remaining 7.
    configure(16'd9, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    tick = 1'b1; cyc(); cyc();
    check_out("rst.pre", S_RUN, 16'd7, 1'b0, 1'b1);
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1; tick = 1'b0;
    check_out("rst.mid", S_IDLE, 16'd0, 1'b0, 1'b0);
    check("rst.cfg_ready", 32'(cfg_ready), 32'd1);
    start = 1'b1; cyc(); start = 1'b0;
    check_out("rst.period1", S_RUN, 16'd1, 1'b0, 1'b1);
    tick = 1'b1; cyc(); tick = 1'b0;
    check_out("rst.oneshot", S_DONE, 16'd0, 1'b1, 1'b0);

    // Max period with same-cycle config bypass.
    cfg_valid = 1'b1; cfg_period = 16'hFFFF; cfg_periodic = 1'b0; start = 1'b1;
    cyc(); cfg_valid = 1'b0; start = 1'b0;
    check_out("max.start", S_RUN, 16'hFFFF, 1'b0, 1'b1);
    tick = 1'b1; cyc(); tick = 1'b0;
    check_out("max.t1", S_RUN, 16'hFFFE, 1'b0, 1'b1);
    stop = 1'b1; cyc(); stop = 1'b0;

    // Start while pause held reloads but stays paused; periodic period 1.
    configure(16'd3, 1'b0);
    start = 1'b1; cyc(); start = 1'b0;
    tick = 1'b1; cyc(); tick = 1'b0;
    pause = 1'b1; cyc();
    check_out("ps.paused", S_PAUSE, 16'd2, 1'b0, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    check_out("ps.restart", S_PAUSE, 16'd3, 1'b0, 1'b1);
    pause = 1'b0; cyc();
    check_out("ps.resume", S_RUN, 16'd3, 1'b0, 1'b1);
    stop = 1'b1; cyc(); stop = 1'b0;
    configure(16'd1, 1'b1);
    start = 1'b1; cyc(); start = 1'b0;
    tick = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_out($sformatf("p1.t%0d", i), S_RUN, 16'd1, 1'b1, 1'b1);
    end
    tick = 1'b0;
    cyc(); check_out("p1.quiet", S_RUN, 16'd1, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
